// File: rtl/mat_mult_pkg.sv
// Shared types and packing helpers for the pipelined 2x2 signed matrix multiplier.
// Matrices travel as 128-bit row-major vectors with element [0][0] in the top 32 bits.
package mat_mult_pkg;

  localparam int ELEM_W = 32;
  localparam int PROD_W = 64;
  localparam int DIM    = 2;
  localparam int VEC_W  = DIM * DIM * ELEM_W;

  typedef logic signed [ELEM_W-1:0] elem_t;
  typedef elem_t mat_t [DIM][DIM];

  function automatic void unpack_mat(input logic [VEC_W-1:0] v, output mat_t m);
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        m[i][j] = v[(DIM*DIM-1-(i*DIM+j))*ELEM_W +: ELEM_W];
      end
    end
  endfunction

  function automatic logic [VEC_W-1:0] pack_mat(input mat_t m);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        v[(DIM*DIM-1-(i*DIM+j))*ELEM_W +: ELEM_W] = m[i][j];
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/mat_mult_dot2.sv
// Two-stage signed dot product x0*y0 + x1*y1: products registered, then sum
// registered after wrapping to the element width. The unregistered sum feeds the trace.
module mat_mult_dot2
  import mat_mult_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  elem_t x0,
  input  elem_t y0,
  input  elem_t x1,
  input  elem_t y1,
  output elem_t sum,
  output elem_t res
);

  logic signed [PROD_W-1:0] p0_r;
  logic signed [PROD_W-1:0] p1_r;
  logic signed [PROD_W:0]   sum_s;
  elem_t                    res_r;

  // stage 1: full-precision products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_r <= '0;
      p1_r <= '0;
    end else begin
      p0_r <= PROD_W'(x0) * PROD_W'(y0);
      p1_r <= PROD_W'(x1) * PROD_W'(y1);
    end
  end

  // 65-bit sum cannot overflow; the cast keeps the low element bits (mod 2^32)
  always_comb begin
    sum_s = (PROD_W+1)'(p0_r) + (PROD_W+1)'(p1_r);
  end

  assign sum = elem_t'(sum_s);

  // stage 2: wrapped result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r <= '0;
    end else begin
      res_r <= sum;
    end
  end

  assign res = res_r;

endmodule

// File: rtl/mat_mult.sv
// Pipelined signed 2x2 matrix multiplier: Res = A x B and Res2 = trace(Res),
// both registered with a two-edge latency and one result per clock.
module mat_mult
  import mat_mult_pkg::*;
#(
  parameter int W = ELEM_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic signed [4*W-1:0] A,
  input  logic signed [4*W-1:0] B,
  output logic signed [4*W-1:0] Res,
  output logic signed [W-1:0]   Res2
);

  mat_t  a_s;
  mat_t  b_s;
  mat_t  sum_s;
  mat_t  res_s;
  elem_t trace_s;
  elem_t res2_r;

  // split the packed operands into element arrays
  always_comb begin
    unpack_mat(A, a_s);
    unpack_mat(B, b_s);
  end

  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      mat_mult_dot2 u_dot2 (
        .clk   (clk),
        .rst_n (rst_n),
        .x0    (a_s[i][0]),
        .y0    (b_s[0][j]),
        .x1    (a_s[i][1]),
        .y1    (b_s[1][j]),
        .sum   (sum_s[i][j]),
        .res   (res_s[i][j])
      );
    end
  end

  // trace taken from the already-wrapped c00/c11 sums, so it lines up with Res
  always_comb begin
    trace_s = sum_s[0][0] + sum_s[1][1];
  end

  // trace register, aligned with the stage-2 element registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res2_r <= '0;
    end else begin
      res2_r <= trace_s;
    end
  end

  assign Res  = pack_mat(res_s);
  assign Res2 = res2_r;

endmodule

// File: tb/tb_mat_mult.sv
// Self-checking bench for mat_mult: table vectors and random vectors through a
// latency-tagged scoreboard, plus reset and mid-stream reset sequences.
module tb_mat_mult;

  logic         clk;
  logic         rst_n;
  logic [127:0] A;
  logic [127:0] B;
  logic [127:0] Res;
  logic [31:0]  Res2;

  mat_mult dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Res   (Res),
    .Res2  (Res2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] res;
    logic [31:0]  tr;
  } vec_t;

  typedef struct {
    logic [127:0] res;
    logic [31:0]  tr;
    int           due;
    int           id;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  function automatic logic [127:0] m4(input int e0, input int e1, input int e2, input int e3);
    return {e0, e1, e2, e3};
  endfunction

  // independent reference: 64-bit products, low 32 bits of each sum
  function automatic void model(input logic [127:0] a, input logic [127:0] b,
                                output logic [127:0] r, output logic [31:0] t);
    longint ea[4];
    longint eb[4];
    logic [63:0] c00, c01, c10, c11;
    for (int k = 0; k < 4; k++) begin
      ea[k] = longint'($signed(a[127-32*k -: 32]));
      eb[k] = longint'($signed(b[127-32*k -: 32]));
    end
    c00 = ea[0]*eb[0] + ea[1]*eb[2];
    c01 = ea[0]*eb[1] + ea[1]*eb[3];
    c10 = ea[2]*eb[0] + ea[3]*eb[2];
    c11 = ea[2]*eb[1] + ea[3]*eb[3];
    r = {c00[31:0], c01[31:0], c10[31:0], c11[31:0]};
    t = c00[31:0] + c11[31:0];
  endfunction

  task automatic chk(input string what, input int id, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s id=%0d got %h expected %h", what, id, act, exp);
    end
  endtask

  task automatic drive(input logic [127:0] a, input logic [127:0] b,
                       input logic [127:0] r, input logic [31:0] t, input int id);
    exp_t e;
    A = a;
    B = b;
    e.res = r;
    e.tr  = t;
    e.due = cyc + 2;
    e.id  = id;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due < cyc) begin
        checks++;
        errors++;
        $display("FAIL overdue id=%0d due %0d now %0d", e.id, e.due, cyc);
      end else begin
        chk("res", e.id, Res, e.res);
        chk("trace", e.id, {96'd0, Res2}, {96'd0, e.tr});
      end
    end
  endtask

  initial begin
    logic [127:0] ra, rb, rr;
    logic [31:0]  rt;

    tbl[0] = '{m4(1, 0, 0, 1),   m4(5, 6, 7, 8), m4(5, 6, 7, 8),   32'd13};
    tbl[1] = '{m4(-1, 2, 3, 4),  m4(1, 2, 3, 2), m4(5, 2, 15, 14), 32'd19};
    tbl[2] = '{m4(-1, 2, 3, 4),  m4(1, 2, 3, 3), m4(5, 4, 15, 18), 32'd23};
    tbl[3] = '{m4(-1, 2, 3, 4),  m4(1, 2, 3, 4), m4(5, 6, 15, 22), 32'd27};
    tbl[4] = '{m4(32'h7FFFFFFF, 0, 0, 1), m4(2, 0, 0, 1),
               m4(32'hFFFFFFFE, 0, 0, 1), 32'hFFFFFFFF};
    tbl[5] = '{m4(-3, 5, 7, -11), m4(13, -17, 19, 23),
               m4(56, 166, -118, -372), 32'hFFFFFEC4};
    tbl[6] = '{m4(32'h80000000, 32'h80000000, 0, 0), m4(32'h80000000, 0, 32'h80000000, 0),
               m4(0, 0, 0, 0), 32'd0};
    tbl[7] = '{m4(0, 0, 0, 0),   m4(9, 9, 9, 9), m4(0, 0, 0, 0),   32'd0};

    // asynchronous reset with nonzero operands present
    rst_n = 1'b1;
    A = m4(1, 2, 3, 4);
    B = m4(5, 6, 7, 8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_res", 0, Res, 128'd0);
    chk("reset_trace", 0, {96'd0, Res2}, 128'd0);
    step();
    step();
    chk("reset_hold", 0, {Res, 96'd0, Res2}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(m4(2, 0, 0, 2), m4(5, 6, 7, 8), m4(10, 12, 14, 16), 32'd26, 100);
    step();
    chk("post_reset_edge1", 100, {Res, 96'd0, Res2}, 256'd0);
    step();

    // back-to-back table vectors
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].tr, i);
      step();
    end

    // random vectors checked against the reference model
    for (int i = 0; i < 12; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      model(ra, rb, rr, rt);
      drive(ra, rb, rr, rt, 200 + i);
      step();
    end

    // mid-stream reset: half-cycle pulse with results in flight
    drive(tbl[1].a, tbl[1].b, tbl[1].res, tbl[1].tr, 300);
    step();
    drive(tbl[5].a, tbl[5].b, tbl[5].res, tbl[5].tr, 301);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_res", 301, Res, 128'd0);
    chk("midreset_trace", 301, {96'd0, Res2}, 128'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(tbl[3].a, tbl[3].b, tbl[3].res, tbl[3].tr, 302);
    step();
    chk("no_stale", 302, {Res, 96'd0, Res2}, 256'd0);
    step();
    step();
    step();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain left %0d entries", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
